// File: rtl/snoop_bus_arbiter.sv
// Round-robin snooping-bus controller: IDLE -> SNOOP -> RESP, one transaction in flight.
// Optional flush-priority arbitration is enabled by defining SNOOP_BUS_FLUSH_EN.
module snoop_bus_arbiter #(
  parameter int N_CORES = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = $clog2(N_CORES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          req_core,
  output logic [N_CORES-1:0]          grant_core,
  input  logic [2*N_CORES-1:0]        bus_operation_in,
  input  logic [ADDR_W*N_CORES-1:0]   bus_address_in,
  input  logic [DATA_W*N_CORES-1:0]   bus_data_in,
  input  logic [N_CORES-1:0]          cache_hit_in,
  input  logic [N_CORES-1:0]          flush_in,
  output logic [2*N_CORES-1:0]        bus_operation_out,
  output logic [ADDR_W*N_CORES-1:0]   bus_address_out,
  output logic [DATA_W*N_CORES-1:0]   bus_data_out,
  output logic [N_CORES-1:0]          cache_hit_out,
  output logic [N_CORES-1:0]          done
);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_SNOOP, ST_RESP} state_t;

  state_t                      r_state, w_next;
  logic [IDX_W-1:0]            r_ptr, r_owner;
  logic [1:0]                  r_op;
  logic [N_CORES-1:0]          r_grant, r_hit_out, r_done;
  logic [2*N_CORES-1:0]        r_op_out;
  logic [ADDR_W*N_CORES-1:0]   r_addr_out;
  logic [DATA_W*N_CORES-1:0]   r_data_out;

  logic [IDX_W-1:0]            w_win, w_src, w_ptr_next;
  logic [1:0]                  w_win_op;
  logic [ADDR_W-1:0]           w_win_addr;
  logic [N_CORES-1:0]          w_win_mask, w_owner_mask, w_peer_hit, w_resp_hit;
  logic [2*N_CORES-1:0]        w_snoop_op;
  logic [ADDR_W*N_CORES-1:0]   w_snoop_addr;
  logic [DATA_W*N_CORES-1:0]   w_resp_data;
  logic                        w_found;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_CORES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // First requester at or after ptr, searching upward with wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CORES-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic             hit;
    int               j;
    pick = ptr;
    hit  = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      j = int'(ptr) + i;
      j = (j >= N_CORES) ? j - N_CORES : j;
      if (!hit && req[j]) begin
        hit  = 1'b1;
        pick = IDX_W'(j);
      end
    end
    return pick;
  endfunction

  function automatic logic [N_CORES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_CORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef SNOOP_BUS_FLUSH_EN
  logic [N_CORES-1:0] w_flush_req;
  // Flushing requesters pre-empt round-robin; lowest index wins, broadcast as BusRdX.
  always_comb begin
    w_flush_req = flush_in & req_core;
    if (|w_flush_req) begin
      w_win    = lowest_idx(w_flush_req);
      w_win_op = OP_RDX;
    end else begin
      w_win    = rr_pick(req_core, r_ptr);
      w_win_op = bus_operation_in[2*int'(w_win) +: 2];
    end
  end
`else
  logic w_unused_flush;
  assign w_unused_flush = ^flush_in;
  // Pure round-robin winner selection.
  always_comb begin
    w_win    = rr_pick(req_core, r_ptr);
    w_win_op = bus_operation_in[2*int'(w_win) +: 2];
  end
`endif

  // Snoop broadcast for the candidate winner and response for the latched owner.
  always_comb begin
    w_found      = |req_core;
    w_win_addr   = bus_address_in[ADDR_W*int'(w_win) +: ADDR_W];
    w_win_mask   = onehot(w_win);
    w_owner_mask = onehot(r_owner);
    w_snoop_op   = {N_CORES{OP_NONE}};
    w_snoop_addr = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (i != int'(w_win)) begin
        w_snoop_op[2*i +: 2]        = w_win_op;
        w_snoop_addr[ADDR_W*i +: ADDR_W] = w_win_addr;
      end else begin
        w_snoop_op[2*i +: 2]        = OP_NONE;
        w_snoop_addr[ADDR_W*i +: ADDR_W] = '0;
      end
    end
    w_peer_hit  = cache_hit_in & ~w_owner_mask;
    w_src       = lowest_idx(w_peer_hit);
    w_resp_data = '0;
    w_resp_hit  = '0;
    if ((r_op == OP_RD || r_op == OP_RDX) && (|w_peer_hit)) begin
      w_resp_data[DATA_W*int'(r_owner) +: DATA_W] = bus_data_in[DATA_W*int'(w_src) +: DATA_W];
      w_resp_hit[r_owner] = 1'b1;
    end else begin
      w_resp_data = '0;
      w_resp_hit  = '0;
    end
    w_ptr_next = (r_owner == IDX_W'(N_CORES - 1)) ? '0 : r_owner + IDX_W'(1);
  end

  // Next-state logic; dropping the request during SNOOP aborts the transaction.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = w_found ? ST_SNOOP : ST_IDLE;
      ST_SNOOP: w_next = req_core[r_owner] ? ST_RESP : ST_IDLE;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_op       <= OP_NONE;
      r_grant    <= '0;
      r_op_out   <= {N_CORES{OP_NONE}};
      r_addr_out <= '0;
      r_data_out <= '0;
      r_hit_out  <= '0;
      r_done     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner    <= w_win;
            r_op       <= w_win_op;
            r_grant    <= w_win_mask;
            r_op_out   <= w_snoop_op;
            r_addr_out <= w_snoop_addr;
          end
        end
        ST_SNOOP: begin
          r_op_out   <= {N_CORES{OP_NONE}};
          r_addr_out <= '0;
          if (req_core[r_owner]) begin
            r_data_out <= w_resp_data;
            r_hit_out  <= w_resp_hit;
            r_done     <= w_owner_mask;
          end else begin
            r_grant    <= '0;
          end
        end
        ST_RESP: begin
          r_grant    <= '0;
          r_data_out <= '0;
          r_hit_out  <= '0;
          r_done     <= '0;
          r_ptr      <= w_ptr_next;
        end
        default: begin
          r_grant    <= '0;
          r_op_out   <= {N_CORES{OP_NONE}};
          r_addr_out <= '0;
          r_data_out <= '0;
          r_hit_out  <= '0;
          r_done     <= '0;
        end
      endcase
    end
  end

  assign grant_core        = r_grant;
  assign bus_operation_out = r_op_out;
  assign bus_address_out   = r_addr_out;
  assign bus_data_out      = r_data_out;
  assign cache_hit_out     = r_hit_out;
  assign done              = r_done;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter with N_CORES=4; flush test follows SNOOP_BUS_FLUSH_EN.
module tb_snoop_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req, grant, hit_in, flush_in, hit_out, done;
  logic [2*N-1:0]    op_in, op_out;
  logic [AW*N-1:0]   addr_in, addr_out;
  logic [DW*N-1:0]   data_in, data_out;
  int vec_cnt = 0;
  int err_cnt = 0;

  snoop_bus_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_core(req), .grant_core(grant),
    .bus_operation_in(op_in), .bus_address_in(addr_in), .bus_data_in(data_in),
    .cache_hit_in(hit_in), .flush_in(flush_in), .bus_operation_out(op_out),
    .bus_address_out(addr_out), .bus_data_out(data_out), .cache_hit_out(hit_out),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req = '0; op_in = {N{2'b11}}; addr_in = '0; data_in = '0; hit_in = '0; flush_in = '0;
  endtask

  task automatic set_req(input int core, input logic [1:0] op, input logic [AW-1:0] addr);
    req[core] = 1'b1;
    op_in[2*core +: 2] = op;
    addr_in[AW*core +: AW] = addr;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    #2 reset = 1'b0;
    #2;
    vec_cnt++; if (grant !== 4'b0000) begin err_cnt++; $display("FAIL rst_grant got %b exp %b", grant, 4'b0000); end
    vec_cnt++; if (op_out !== 8'hFF) begin err_cnt++; $display("FAIL rst_op got %h exp %h", op_out, 8'hFF); end
    vec_cnt++; if (addr_out !== '0) begin err_cnt++; $display("FAIL rst_addr got %h exp 0", addr_out); end
    vec_cnt++; if (data_out !== '0 || hit_out !== '0 || done !== '0) begin err_cnt++; $display("FAIL rst_resp got data %h hit %b done %b exp 0", data_out, hit_out, done); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_read;
    do_reset();
    set_req(1, 2'b00, 32'h100);
    hit_in[0] = 1'b1;
    data_in[31:0] = 32'hDEADBEEF;
    tick();
    vec_cnt++; if (grant !== 4'b0010) begin err_cnt++; $display("FAIL rd_grant got %b exp %b", grant, 4'b0010); end
    vec_cnt++; if (op_out !== 8'b00_00_11_00) begin err_cnt++; $display("FAIL rd_snoop_op got %b exp %b", op_out, 8'b00_00_11_00); end
    vec_cnt++; if (addr_out[31:0] !== 32'h100 || addr_out[63:32] !== 32'h0) begin err_cnt++; $display("FAIL rd_snoop_addr got %h exp slot0=100 slot1=0", addr_out); end
    vec_cnt++; if (done !== 4'b0000) begin err_cnt++; $display("FAIL rd_done_early got %b exp %b", done, 4'b0000); end
    tick();
    vec_cnt++; if (done !== 4'b0010) begin err_cnt++; $display("FAIL rd_done got %b exp %b", done, 4'b0010); end
    vec_cnt++; if (data_out[63:32] !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL rd_data got %h exp %h", data_out[63:32], 32'hDEADBEEF); end
    vec_cnt++; if (hit_out !== 4'b0010) begin err_cnt++; $display("FAIL rd_hit got %b exp %b", hit_out, 4'b0010); end
    vec_cnt++; if (op_out !== 8'hFF) begin err_cnt++; $display("FAIL rd_op_resp got %h exp %h", op_out, 8'hFF); end
    idle_inputs();
    tick();
    vec_cnt++; if (grant !== 4'b0000 || done !== 4'b0000) begin err_cnt++; $display("FAIL rd_idle got grant %b done %b exp 0", grant, done); end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] seen [5];
    int           at [5];
    int           n;
    logic [N-1:0] prev;
    logic [N-1:0] exp_g;
    bit           onehot_ok;
    do_reset();
    n = 0; prev = '0; onehot_ok = 1'b1;
    req = 4'b1111; op_in = 8'h00;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (!$onehot0(grant)) onehot_ok = 1'b0;
      if (grant != 4'b0000 && prev == 4'b0000 && n < 5) begin
        seen[n] = grant; at[n] = c; n++;
      end
      prev = grant;
    end
    vec_cnt++; if (!onehot_ok) begin err_cnt++; $display("FAIL rr_onehot got multi-grant exp at most one"); end
    vec_cnt++; if (n !== 5) begin err_cnt++; $display("FAIL rr_count got %0d exp 5", n); end
    for (int i = 0; i < n; i++) begin
      exp_g = 4'b0001 << (i % 4);
      vec_cnt++; if (seen[i] !== exp_g) begin err_cnt++; $display("FAIL rr_order[%0d] got %b exp %b", i, seen[i], exp_g); end
      vec_cnt++; if (at[i] !== 3 * i) begin err_cnt++; $display("FAIL rr_spacing[%0d] got cycle %0d exp %0d", i, at[i], 3 * i); end
    end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_rdx_source;
    logic [DW*N-1:0] exp_d;
    do_reset();
    set_req(2, 2'b10, 32'h200);
    hit_in = 4'b1010;
    data_in[63:32] = 32'h11;
    data_in[127:96] = 32'h33;
    tick();
    vec_cnt++; if (grant !== 4'b0100) begin err_cnt++; $display("FAIL rdx_grant got %b exp %b", grant, 4'b0100); end
    vec_cnt++; if (op_out !== 8'b10_11_10_10) begin err_cnt++; $display("FAIL rdx_op got %b exp %b", op_out, 8'b10_11_10_10); end
    tick();
    exp_d = '0;
    exp_d[95:64] = 32'h11;
    vec_cnt++; if (data_out !== exp_d) begin err_cnt++; $display("FAIL rdx_data got %h exp %h", data_out, exp_d); end
    vec_cnt++; if (hit_out !== 4'b0100 || done !== 4'b0100) begin err_cnt++; $display("FAIL rdx_hit_done got %b/%b exp 0100/0100", hit_out, done); end
    idle_inputs();
    tick();
  endtask

  task automatic test_upgrade;
    do_reset();
    set_req(0, 2'b01, 32'h300);
    hit_in = 4'b1110;
    data_in = {4{32'hAAAA5555}};
    tick();
    vec_cnt++; if (grant !== 4'b0001) begin err_cnt++; $display("FAIL upgr_grant got %b exp %b", grant, 4'b0001); end
    vec_cnt++; if (op_out !== 8'b01_01_01_11) begin err_cnt++; $display("FAIL upgr_op got %b exp %b", op_out, 8'b01_01_01_11); end
    vec_cnt++; if (addr_out[63:32] !== 32'h300) begin err_cnt++; $display("FAIL upgr_addr got %h exp %h", addr_out[63:32], 32'h300); end
    tick();
    vec_cnt++; if (data_out !== '0 || hit_out !== 4'b0000) begin err_cnt++; $display("FAIL upgr_resp got data %h hit %b exp 0", data_out, hit_out); end
    vec_cnt++; if (done !== 4'b0001) begin err_cnt++; $display("FAIL upgr_done got %b exp %b", done, 4'b0001); end
    idle_inputs();
    tick();
  endtask

  task automatic test_hit_window;
    do_reset();
    set_req(1, 2'b00, 32'h40);
    hit_in = 4'b0001;
    data_in[31:0] = 32'h5555;
    tick();
    hit_in = 4'b0000;
    tick();
    vec_cnt++; if (hit_out !== 4'b0000 || data_out !== '0) begin err_cnt++; $display("FAIL win_snoop got hit %b data %h exp 0", hit_out, data_out); end
    vec_cnt++; if (done !== 4'b0010) begin err_cnt++; $display("FAIL win_done got %b exp %b", done, 4'b0010); end
    idle_inputs();
    hit_in = 4'b0001;
    data_in[31:0] = 32'h5555;
    tick();
    vec_cnt++; if (hit_out !== 4'b0000 || data_out !== '0 || done !== 4'b0000) begin err_cnt++; $display("FAIL win_late got hit %b data %h done %b exp 0", hit_out, data_out, done); end
    idle_inputs();
  endtask

  task automatic test_abort;
    do_reset();
    set_req(0, 2'b00, 32'h80);
    tick();
    vec_cnt++; if (grant !== 4'b0001) begin err_cnt++; $display("FAIL abort_grant got %b exp %b", grant, 4'b0001); end
    req = 4'b0000;
    tick();
    vec_cnt++; if (grant !== 4'b0000 || done !== 4'b0000 || op_out !== 8'hFF) begin err_cnt++; $display("FAIL abort_clear got grant %b done %b op %h exp 0/0/ff", grant, done, op_out); end
    set_req(0, 2'b00, 32'h80);
    set_req(1, 2'b00, 32'h90);
    tick();
    vec_cnt++; if (grant !== 4'b0001) begin err_cnt++; $display("FAIL abort_ptr got %b exp %b", grant, 4'b0001); end
    tick();
    vec_cnt++; if (done !== 4'b0001) begin err_cnt++; $display("FAIL abort_next_done got %b exp %b", done, 4'b0001); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_req(1, 2'b10, 32'h500);
    tick();
    vec_cnt++; if (grant !== 4'b0010) begin err_cnt++; $display("FAIL mid_grant got %b exp %b", grant, 4'b0010); end
    reset = 1'b0;
    #2;
    vec_cnt++; if (grant !== 4'b0000 || op_out !== 8'hFF || addr_out !== '0) begin err_cnt++; $display("FAIL mid_async got grant %b op %h addr %h exp 0/ff/0", grant, op_out, addr_out); end
    tick();
    reset = 1'b1;
    idle_inputs();
    set_req(2, 2'b00, 32'h600);
    set_req(3, 2'b00, 32'h700);
    tick();
    vec_cnt++; if (grant !== 4'b0100) begin err_cnt++; $display("FAIL mid_rearb got %b exp %b", grant, 4'b0100); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_flush;
    do_reset();
    set_req(0, 2'b00, 32'h10);
    set_req(3, 2'b00, 32'h20);
    flush_in = 4'b1000;
    tick();
`ifdef SNOOP_BUS_FLUSH_EN
    vec_cnt++; if (grant !== 4'b1000) begin err_cnt++; $display("FAIL flush_grant got %b exp %b", grant, 4'b1000); end
    vec_cnt++; if (op_out !== 8'b11_10_10_10) begin err_cnt++; $display("FAIL flush_op got %b exp %b", op_out, 8'b11_10_10_10); end
    tick();
    vec_cnt++; if (done !== 4'b1000) begin err_cnt++; $display("FAIL flush_done got %b exp %b", done, 4'b1000); end
`else
    vec_cnt++; if (grant !== 4'b0001) begin err_cnt++; $display("FAIL noflush_grant got %b exp %b", grant, 4'b0001); end
    vec_cnt++; if (op_out !== 8'b00_00_00_11) begin err_cnt++; $display("FAIL noflush_op got %b exp %b", op_out, 8'b00_00_00_11); end
    tick();
    vec_cnt++; if (done !== 4'b0001) begin err_cnt++; $display("FAIL noflush_done got %b exp %b", done, 4'b0001); end
`endif
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_round_robin();
    test_rdx_source();
    test_upgrade();
    test_hit_window();
    test_abort();
    test_reset_mid();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Parametrised snooping-bus controller for an N-core MSI/MESI cache system: arbitrates between per-core bus requests with a registered round-robin grant, broadcasts the winning transaction to all other cores' snoop ports, collects their hit responses, and returns forwarded data to the requester. It is the successor to the two-core combinational bus controller. Arbitration and the transaction are sequenced by an FSM, so at most one transaction is in flight.

## Interface
- `N_CORES`, default 2, number of cores; must be at least 2.
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width.
- `IDX_W`, default `$clog2(N_CORES)`, owner-index width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_core`  in  N_CORES  per-core bus request; held until `done`.
- `grant_core`  out  N_CORES  one-hot owner; all zero when idle.
- `bus_operation_in`  in  2*N_CORES  per-core op, core i at [2i+1:2i]. Encoding: BusRd=00, BusUpgr=01, BusRdX=10, None=11.
- `bus_address_in`  in  ADDR_W*N_CORES  per-core request address.
- `bus_data_in`  in  DATA_W*N_CORES  per-core snoop data, valid with the hit.
- `cache_hit_in`  in  N_CORES  per-core snoop hit.
- `flush_in`  in  N_CORES  per-core flush request; used only with `SNOOP_BUS_FLUSH_EN`.
- `bus_operation_out`  out  2*N_CORES  snoop op to each core; 11 when not snooped.
- `bus_address_out`  out  ADDR_W*N_CORES  snoop address to each core.
- `bus_data_out`  out  DATA_W*N_CORES  forwarded data to the owner slot only.
- `cache_hit_out`  out  N_CORES  "a peer hit" to the owner slot only.
- `done`  out  N_CORES  one-cycle completion pulse to the owner.

## Operation
**Reset values**
- Every output register is reset: `grant_core`=0, all `bus_operation_out`=11, addresses and data =0, `cache_hit_out`=0, `done`=0.
- The round-robin pointer resets to 0, so core 0 has highest priority first.

**FSM states: IDLE, SNOOP, RESP.**
- **IDLE:** if any `req_core` bit is set, pick a winner.
  - Winner is the first requesting index at or after the pointer, searching upward with wrap.
  - Latch the winner's index, op and address; assert its `grant_core` bit; go to SNOOP.
- **SNOOP:**
  - For every core except the owner, drive `bus_operation_out` = latched op and `bus_address_out` = latched address.
  - The owner slot keeps op 11.
  - At the end of SNOOP, sample `cache_hit_in` of the non-owners. The data source is the lowest-index hitting non-owner.
  - Go to RESP.
- **RESP:**
  - All snoop ops return to 11.
  - For BusRd or BusRdX, drive the owner's `bus_data_out` slot with the source data and its `cache_hit_out` with the OR of peer hits.
  - For BusUpgr or None, drive data 0 and hit 0.
  - Pulse the owner's `done`.
  - Set pointer = owner+1, wrapping from N_CORES-1 to 0.
  - Drop the grant and go to IDLE.
- **BusUpgr** is broadcast for peer invalidation. This is behaviour the old controller lacked.
- **Op None with request:** the transaction still runs and completes with no snoop broadcast; all ops stay 11.
- **Abort:** if the owner drops `req_core` during SNOOP, go to IDLE on the next edge with no `done`, clear the grant, and leave the pointer unchanged.
- **Reset mid-transaction:** outputs return to reset values immediately (asynchronously), and the FSM returns to IDLE.

## Timing
- `req_core` sampled high at edge k (in IDLE) gives: `grant_core` and snoop outputs valid after edge k, `done` and response valid after edge k+1, back in IDLE after edge k+2.
- Peak throughput is one transaction per 3 cycles. A request that is still held is re-arbitrated in the IDLE cycle that follows.
- Every output is registered; there are no combinational paths from input to output.
- Simultaneous requests: exactly one grant. A request that arrives while a transaction is in flight waits.
- Pointer wrap: after core N_CORES-1 is served, core 0 has priority.
- Hits are sampled only at the end of SNOOP. Hits at any other time are ignored.

## Configuration
- **`SNOOP_BUS_FLUSH_EN` defined:**
  - In IDLE, any `flush_in` bit set whose `req_core` is also set overrides round-robin. Among such cores, the lowest index wins.
  - A flush transaction is broadcast as BusRdX regardless of `bus_operation_in`.
  - The pointer still advances past the winner.
- **Not defined:** `flush_in` is ignored, and arbitration is pure round-robin.

## Test plan
- Reset, then core 1 requests BusRd at address 0x100 while core 0 hits with data 0xDEADBEEF:
  - grant=0b10 one cycle after the request is sampled;
  - core 0 sees op 00 and address 0x100;
  - core 1 gets data 0xDEADBEEF and hit=1 with done=0b10 one cycle later.
- N_CORES=4, all cores requesting continuously → grants go 0,1,2,3,0, with a 3-cycle spacing between each.
- N_CORES=4, core 2 BusRdX with cores 1 and 3 hitting (data 0x11 and 0x33) → core 2 receives 0x11 with hit=1.
- Core 0 BusUpgr → cores 1 and above see op 01; core 0 gets data 0 and hit 0, with done pulsed.
- Core 0 drops `req_core` during SNOOP → no done; state is IDLE next cycle; a later simultaneous request from cores 0 and 1 grants core 0.
- With `SNOOP_BUS_FLUSH_EN` and N_CORES=4: pointer at 0, cores 0 and 3 requesting, core 3 flushing → core 3 is granted first, with op 10 broadcast.
